// File: rtl/sm_calc_pkg.sv
// Shared types, widths and sign normalisation for the sign-magnitude calculator units.
// Operands are {sign, MAG_W-bit magnitude}; results are {sign, 2*MAG_W-bit magnitude}.
package sm_calc_pkg;

   localparam int unsigned MAG_W    = 2;
   localparam int unsigned SIGN_IN  = 2;
   localparam int unsigned SIGN_OUT = 4;
   localparam int unsigned OP_W     = MAG_W + 1;
   localparam int unsigned ACC_W    = 2 * MAG_W;
   localparam int unsigned RES_W    = 2 * MAG_W + 1;
   localparam int unsigned CNT_W    = $clog2(MAG_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [ACC_W-1:0] mag;
   } sm_res_t;

   // Zero magnitude always carries a positive sign, so no unit emits negative zero.
   function automatic sm_res_t sm_norm(input logic sign, input logic [ACC_W-1:0] mag);
      sm_res_t r;
      r.sign = sign & (|mag);
      r.mag  = mag;
      return r;
   endfunction

endpackage

// File: rtl/sm_seq_mul_if.sv
// Start/busy/done handshake bundle between the operation select and the multiplier.
interface sm_seq_mul_if;
   import sm_calc_pkg::*;

   logic             start;
   logic [OP_W-1:0]  a;
   logic [OP_W-1:0]  b;
   logic             busy;
   logic             done;
   logic [RES_W-1:0] product;
   logic             zeroflag;

   modport master (
      output start, a, b,
      input  busy, done, product, zeroflag
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, zeroflag
   );

endinterface

// File: rtl/sm_seq_mul.sv
// Sequential shift-and-add sign-magnitude multiplier, one partial product per clock.
// Fixed latency: done pulses MAG_W+1 cycles after the start edge, independent of operands.
module sm_seq_mul
   import sm_calc_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   sm_seq_mul_if.slave  bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [MAG_W-1:0]  r_mag_a;
   logic [MAG_W-1:0]  w_mag_a_nxt;
   logic [MAG_W-1:0]  r_mag_b;
   logic [MAG_W-1:0]  w_mag_b_nxt;
   logic              r_sgn;
   logic              w_sgn_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_acc_nxt;
   sm_res_t           r_product;
   sm_res_t           w_product_nxt;
   logic              r_zero;
   logic              w_zero_nxt;
   logic              r_busy;
   logic              w_busy_nxt;
   logic              r_done;
   logic              w_done_nxt;

   logic [MAG_W-1:0]  w_b_sh;
   logic              w_bit;
   logic [ACC_W-1:0]  w_pp;
   logic [ACC_W-1:0]  w_acc_sum;
   logic              w_last;
   sm_res_t           w_res;

   // Current multiplier bit selects whether the shifted multiplicand is accumulated.
   assign w_b_sh    = r_mag_b >> r_count;
   assign w_bit     = w_b_sh[0];
   assign w_pp      = w_bit ? (ACC_W'(r_mag_a) << r_count) : '0;
   assign w_acc_sum = r_acc + w_pp;
   assign w_last    = (r_count == CNT_W'(MAG_W - 1));
   assign w_res     = sm_norm(r_sgn, w_acc_sum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_sgn     <= 1'b0;
         r_acc     <= '0;
         r_product <= '0;
         r_zero    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_mag_a   <= w_mag_a_nxt;
         r_mag_b   <= w_mag_b_nxt;
         r_sgn     <= w_sgn_nxt;
         r_acc     <= w_acc_nxt;
         r_product <= w_product_nxt;
         r_zero    <= w_zero_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Next-state and next-output logic; busy/done are registered alongside the state.
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_mag_a_nxt   = r_mag_a;
      w_mag_b_nxt   = r_mag_b;
      w_sgn_nxt     = r_sgn;
      w_acc_nxt     = r_acc;
      w_product_nxt = r_product;
      w_zero_nxt    = r_zero;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_mag_a_nxt = bus.a[MAG_W-1:0];
               w_mag_b_nxt = bus.b[MAG_W-1:0];
               w_sgn_nxt   = bus.a[SIGN_IN] ^ bus.b[SIGN_IN];
               w_acc_nxt   = '0;
               w_count_nxt = '0;
               w_state_nxt = CALC;
               w_busy_nxt  = 1'b1;
            end
         end
         CALC: begin
            w_acc_nxt   = w_acc_sum;
            w_count_nxt = r_count + CNT_W'(1);
            if (w_last) begin
               w_state_nxt   = DONE;
               w_product_nxt = w_res;
               w_zero_nxt    = (w_acc_sum == '0);
               w_done_nxt    = 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.product  = r_product;
   assign bus.zeroflag = r_zero;

endmodule

// File: tb/tb_sm_seq_mul.sv
// Self-checking bench for sm_seq_mul: directed literal cases, an every-cycle
// comparison against a transaction-level model, and a back-to-back sweep of all operands.
module tb_sm_seq_mul;
   import sm_calc_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;

   sm_seq_mul_if u_if();

   sm_seq_mul u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference product from plain integer arithmetic on the magnitudes.
   function automatic logic [4:0] ref_prod(input logic [2:0] x, input logic [2:0] y);
      int   p;
      logic s;
      p = int'(x[1:0]) * int'(y[1:0]);
      s = (x[2] ^ y[2]) && (p != 0);
      return {s, 4'(p)};
   endfunction

   // Transaction model: an accepted start keeps the unit busy MAG_W+1 cycles, the last being done.
   int         m_left;
   logic [4:0] m_prod;
   logic [4:0] m_pend;
   logic       m_zero;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_prod <= 5'd0;
         m_pend <= 5'd0;
         m_zero <= 1'b1;
      end else if (m_left == 0) begin
         if (u_if.start) begin
            m_pend <= ref_prod(u_if.a, u_if.b);
            m_left <= int'(MAG_W) + 1;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) begin
            m_prod <= m_pend;
            m_zero <= (m_pend[3:0] == 4'd0);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the done pulse and captures the result in that cycle.
   task automatic wait_done(output logic found, output logic [4:0] prod, output logic zf,
                            output int lat, output int dcyc);
      found = 1'b0;
      prod  = 5'd0;
      zf    = 1'b0;
      lat   = -1;
      dcyc  = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (u_if.done) begin
            found = 1'b1;
            prod  = u_if.product;
            zf    = u_if.zeroflag;
            lat   = i;
            dcyc  = cyc;
            break;
         end
      end
      if (!found) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [2:0] ta, input logic [2:0] tb_b,
                         output logic [4:0] prod, output logic zf, output int lat,
                         output int dcyc);
      logic found;
      u_if.a     = ta;
      u_if.b     = tb_b;
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      wait_done(found, prod, zf, lat, dcyc);
      tick();
   endtask

   task automatic count_dones(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (u_if.done) n++;
      end
   endtask

   initial begin
      logic [4:0] prod;
      logic       zf;
      logic       found;
      logic [5:0] v;
      int         lat;
      int         dcyc;
      int         prev_dcyc;
      int         nd;

      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      rst_n      = 1'b0;
      u_if.start = 1'b0;
      u_if.a     = 3'd0;
      u_if.b     = 3'd0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n)
               check("cycle", {24'd0, u_if.busy, u_if.done, u_if.zeroflag, u_if.product},
                     {24'd0, (m_left != 0), (m_left == 1), m_zero, m_prod});
         end
      join_none

      repeat (3) tick();
      check("rst_busy",    32'(u_if.busy),     32'd0);
      check("rst_done",    32'(u_if.done),     32'd0);
      check("rst_product", 32'(u_if.product),  32'd0);
      check("rst_zero",    32'(u_if.zeroflag), 32'd1);
      rst_n = 1'b1;
      tick();

      // 3 * 3 = +9
      run_op(3'b011, 3'b011, prod, zf, lat, dcyc);
      check("p33",     32'(prod), 32'b01001);
      check("z33",     32'(zf),   32'd0);
      check("lat33",   32'(lat),  32'd3);

      // -3 * +2 = -6 ; -2 * -3 = +6
      run_op(3'b111, 3'b010, prod, zf, lat, dcyc);
      check("p_m3p2",  32'(prod), 32'b10110);
      run_op(3'b110, 3'b111, prod, zf, lat, dcyc);
      check("p_m2m3",  32'(prod), 32'b00110);
      check("z_m2m3",  32'(zf),   32'd0);

      // Zero results never carry a negative sign
      run_op(3'b100, 3'b111, prod, zf, lat, dcyc);
      check("p_negz",  32'(prod), 32'b00000);
      check("z_negz",  32'(zf),   32'd1);
      run_op(3'b101, 3'b000, prod, zf, lat, dcyc);
      check("p_m1x0",  32'(prod), 32'b00000);
      check("z_m1x0",  32'(zf),   32'd1);

      // Start during CALC is ignored; exactly one done follows
      u_if.a     = 3'b011;
      u_if.b     = 3'b011;
      u_if.start = 1'b1;
      tick();
      u_if.a     = 3'b001;
      u_if.b     = 3'b001;
      tick();
      u_if.start = 1'b0;
      wait_done(found, prod, zf, lat, dcyc);
      check("p_busy_start", 32'(prod), 32'b01001);
      tick();
      count_dones(6, nd);
      check("extra_done", 32'(nd), 32'd0);
      tick();

      // Reset in the middle of CALC discards the operation
      u_if.a     = 3'b011;
      u_if.b     = 3'b010;
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy",    32'(u_if.busy),     32'd0);
      check("mid_rst_done",    32'(u_if.done),     32'd0);
      check("mid_rst_product", 32'(u_if.product),  32'd0);
      check("mid_rst_zero",    32'(u_if.zeroflag), 32'd1);
      tick();
      rst_n = 1'b1;
      count_dones(5, nd);
      check("done_after_rst", 32'(nd), 32'd0);
      tick();
      run_op(3'b010, 3'b010, prod, zf, lat, dcyc);
      check("p_after_rst", 32'(prod), 32'b00100);

      // All operand pairs, each issued in the first IDLE cycle after the previous done
      prev_dcyc = 0;
      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         run_op(v[5:3], v[2:0], prod, zf, lat, dcyc);
         check("sweep_p", 32'(prod), 32'(ref_prod(v[5:3], v[2:0])));
         check("sweep_z", 32'(zf),   32'(ref_prod(v[5:3], v[2:0]) == 5'd0));
         if (i > 0) check("sweep_rate", 32'(dcyc - prev_dcyc), 32'(MAG_W + 2));
         prev_dcyc = dcyc;
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_seq_mul.md
Name: sm_seq_mul

Overview:
Sequential shift-and-add multiplier for the 3-bit signed calculator. It is the multiply counterpart of the divide/remainder path.
- Operands use the calculator's sign-magnitude format: bit 2 = sign, bits 1:0 = magnitude.
- Result is returned in the same 5-bit result format as the remainder unit: bit 4 = sign, bits 3:0 = magnitude.
- Sits beside the div/rem units behind the calculator's operation select, using a start/busy/done handshake.

Parameters:
MAG_W, 2, operand magnitude width. Operand width is MAG_W+1; result width is 2*MAG_W+1; iteration count is MAG_W.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  MAG_W+1  multiplicand, sign-magnitude.
b  input  MAG_W+1  multiplier, sign-magnitude.
busy  output  1  high while in CALC or DONE.
done  output  1  one-cycle pulse; product valid.
product  output  2*MAG_W+1  sign-magnitude result, held until the next done.
zeroflag  output  1  high when the product magnitude is 0; updated together with product.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, internal accumulator/operand registers=0, product=0, zeroflag=1, busy=0, done=0. Takes effect immediately, including mid-CALC. The in-flight operation is discarded and no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: latch mag_a=a[1:0], mag_b=b[1:0], sgn=a[2]^b[2]; clear acc; count=0; go to CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge:
  - if mag_b[count]=1 then acc += mag_a << count; count++.
  - After the edge that performs iteration MAG_W-1, go to DONE.
  - In that same edge, load product = {sgn_final, acc_final} and zeroflag = (acc_final==0).
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k; done is high in the cycle after edge k+MAG_W (edge k+2 for MAG_W=2); IDLE again after edge k+MAG_W+1. Latency is fixed and does not depend on operand values.
- Width: acc is 2*MAG_W bits and cannot overflow (max 3*3=9 fits in 4 bits).
- Sign rule:
  - sgn_final = sgn when acc_final != 0.
  - Forced to 0 when acc_final == 0, so the unit never emits negative zero.
  - Operand negative zero (3'b100) is treated as magnitude 0.
- start while busy (CALC or DONE): ignored, with no queuing. a/b changes during CALC have no effect because operands are latched.
- start in the first IDLE cycle after DONE: accepted normally, so back-to-back rate is one result per MAG_W+2 cycles.
- product/zeroflag are stable from the done cycle until overwritten at the next DONE entry.

Decomposition:
- Shared package sm_calc_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - constants SIGN_IN=2, SIGN_OUT=4, MAG_W=2;
  - function sm_norm(sign, mag), which returns 0 sign on zero magnitude and is reused by the rem/div units.
- No sub-module: the datapath and FSM are small enough to stay in a single module.

Test Plan:
- After reset, start with a=011, b=011 -> done two cycles after the capture edge; product=01001, zeroflag=0.
- a=111 (-3), b=010 (+2) -> product=10110; a=110 (-2), b=111 (-3) -> product=00110.
- a=100 (-0), b=111 (-3) -> product=00000, zeroflag=1. a=101, b=000 -> product=00000 with sign 0.
- start with a=011, b=011, then assert start again with a=001, b=001 during CALC -> second start ignored; single done pulse with product=01001.
- Start a=011, b=010, then pull rst_n low one cycle into CALC -> outputs zero immediately; no done pulse. After release, a fresh start with a=010, b=010 gives product=00100.
- Exhaustive sweep of all 64 a/b pairs back-to-back, each issued in the first IDLE cycle: every product matches the sm_norm reference, and done occurs every MAG_W+2 cycles.
